// File: rtl/m_button_input.sv
// m_button_input: turns the three raw board buttons (INC, DEC, OK) into clean
// single-cycle one-hot command pulses for the Connect-Four play controller.
// Pipeline: 2-FF synchronizer -> per-button debounce -> press-edge detect ->
// priority/ownership FSM with auto-repeat for INC/DEC -> registered output.
//
// Interface semantics: o_user_input is a valid-only pulse stream. A nonzero
// one-hot value is a command that is valid for exactly the cycle it is shown;
// there is no ready and the consumer cannot stall it. 4'b0000 means no command.
module m_button_input #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD   = 15_000_000,
    parameter int unsigned CNT_W           = 26
) (
    input  logic       w_clk,
    input  logic       w_rst,
    input  logic [2:0] i_btn,
    output logic [3:0] o_user_input,
    output logic [2:0] o_btn_level,
    output logic [1:0] o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    // Terminal counts are "value minus one" because a counter that starts at 0
    // on the event edge fires on the edge where it already holds N-1.
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'((REPEAT_DELAY == 0) ? 32'd0 : REPEAT_DELAY - 32'd1);
    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam bit               REPEAT_EN = (REPEAT_DELAY != 0);

    logic [2:0]       sync1;
    logic [2:0]       s;
    logic [2:0]       lvl;
    logic [2:0]       lvl_d;
    logic [CNT_W-1:0] db_cnt [3];

    logic [2:0]       press;
    logic [2:0]       win;

    state_t           state, state_n;
    logic [2:0]       owner, owner_n;
    logic [CNT_W-1:0] rcnt, rcnt_n;
    logic [2:0]       pulse_q, pulse_n;

    // Two-flop synchronizer for the asynchronous button pins.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            sync1 <= '0;
            s     <= '0;
        end else begin
            sync1 <= i_btn;
            s     <= sync1;
        end
    end

    // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive
    // disagreeing samples; any agreeing sample clears the run counter.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            lvl <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (s[i] == lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    lvl[i]    <= s[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    // Delayed copy of the debounced level for rising-edge (press) detection.
    always_ff @(posedge w_clk) begin
        if (w_rst) lvl_d <= '0;
        else       lvl_d <= lvl;
    end

    // Press events and their priority winner: OK > DEC > INC.
    always_comb begin
        press = lvl & ~lvl_d;
        win   = 3'b000;
        if (press[2])      win = 3'b100;
        else if (press[1]) win = 3'b010;
        else if (press[0]) win = 3'b001;
    end

    // FSM state, owner, repeat counter and output pulse registers.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state   <= ST_IDLE;
            owner   <= '0;
            rcnt    <= '0;
            pulse_q <= '0;
        end else begin
            state   <= state_n;
            owner   <= owner_n;
            rcnt    <= rcnt_n;
            pulse_q <= pulse_n;
        end
    end

    // Next-state logic. A new press always wins; then the owner's release;
    // only then the repeat timers. Release beating repeat guarantees no
    // repeat pulse appears once the owner's level has fallen.
    always_comb begin
        state_n = state;
        owner_n = owner;
        rcnt_n  = rcnt;
        pulse_n = 3'b000;
        if (|press) begin
            pulse_n = win;
            owner_n = win;
            rcnt_n  = '0;
            state_n = (win[2] || !REPEAT_EN) ? ST_IDLE : ST_HOLD;
        end else if ((state != ST_IDLE) && !(|(owner & lvl))) begin
            state_n = ST_IDLE;
            owner_n = '0;
            rcnt_n  = '0;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (rcnt == RD_LAST) begin
                        pulse_n = owner;
                        state_n = ST_REPEAT;
                        rcnt_n  = '0;
                    end else begin
                        rcnt_n = rcnt + CNT_ONE;
                    end
                end
                ST_REPEAT: begin
                    if (rcnt == RP_LAST) begin
                        pulse_n = owner;
                        rcnt_n  = '0;
                    end else begin
                        rcnt_n = rcnt + CNT_ONE;
                    end
                end
                default: begin
                    rcnt_n = '0;
                end
            endcase
        end
    end

    assign o_user_input = {1'b0, pulse_q};
    assign o_btn_level  = lvl;
    assign o_dbg_state  = state;

endmodule

// File: tb/tb_m_button_input.sv
// Directed bench for m_button_input with D=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
// Every nonzero output is logged as {edge_index, code}; each scenario lists
// the pulses it must produce with hand-computed edge indices.
// Timing reference: inputs written 1 time unit after edge c are first sampled
// at edge k=c+1, so a held press pulses after edge c+7 (k+D+2).
module tb_m_button_input;

    logic       w_clk;
    logic       w_rst;
    logic [2:0] i_btn;
    logic [3:0] o_user_input;
    logic [2:0] o_btn_level;
    logic [1:0] o_dbg_state;

    int cyc;
    int total;
    int bad;
    bit mon_en;

    logic [19:0] exp_q[$];
    logic [19:0] obs_q[$];

    m_button_input #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (5),
        .CNT_W          (8)
    ) dut (
        .w_clk       (w_clk),
        .w_rst       (w_rst),
        .i_btn       (i_btn),
        .o_user_input(o_user_input),
        .o_btn_level (o_btn_level),
        .o_dbg_state (o_dbg_state)
    );

    // Clock and edge counter.
    initial begin
        w_clk = 1'b0;
        forever #5 w_clk = ~w_clk;
    end

    always @(posedge w_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance n edges, then sit 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge w_clk);
        #1;
    endtask

    task automatic expect_pulse(input int c, input logic [3:0] v);
        exp_q.push_back({16'(c), v});
    endtask

    task automatic score(input string tag);
        int n;
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_pulse"}, {12'd0, obs_q[i]}, {12'd0, exp_q[i]});
        obs_q.delete();
        exp_q.delete();
    endtask

    // Monitor: output must be one-hot or zero with bit3 clear; log pulses.
    always @(negedge w_clk) begin
        if (mon_en) begin
            check("onehot", {31'd0, ($onehot0(o_user_input) && !o_user_input[3])}, 32'd1);
            if (o_user_input != 4'b0000) obs_q.push_back({cyc[15:0], o_user_input});
        end
    end

    initial begin
        int c;
        cyc    = 0;
        total  = 0;
        bad    = 0;
        mon_en = 1'b0;
        w_rst  = 1'b1;
        i_btn  = 3'b000;
        step(3);
        check("rst_out",   {28'd0, o_user_input}, 32'd0);
        check("rst_level", {29'd0, o_btn_level},  32'd0);
        check("rst_state", {30'd0, o_dbg_state},  32'd0);
        w_rst  = 1'b0;
        mon_en = 1'b1;
        step(4);

        // 1: bounce on INC (2 high / 2 low, 20 cycles) then a clean hold.
        for (int i = 0; i < 5; i++) begin
            i_btn[0] = 1'b1; step(2);
            i_btn[0] = 1'b0; step(2);
        end
        check("s1_no_level", {29'd0, o_btn_level}, 32'd0);
        c = cyc;
        i_btn[0] = 1'b1;
        expect_pulse(c + 7, 4'b0001);
        step(6);
        check("s1_before", {28'd0, o_user_input}, 32'd0);
        step(1);
        check("s1_pulse", {28'd0, o_user_input}, 32'h1);
        check("s1_level", {29'd0, o_btn_level}, 32'h1);
        i_btn[0] = 1'b0;            // level falls at c+13, before the c+17 repeat
        step(14);
        score("s1");

        // 2: DEC held 40 cycles: press, delay repeat, period repeats.
        c = cyc;
        i_btn[1] = 1'b1;
        expect_pulse(c + 7,  4'b0010);
        expect_pulse(c + 17, 4'b0010);
        expect_pulse(c + 22, 4'b0010);
        expect_pulse(c + 27, 4'b0010);
        expect_pulse(c + 32, 4'b0010);
        expect_pulse(c + 37, 4'b0010);
        expect_pulse(c + 42, 4'b0010);
        step(10);
        check("s2_state_hold", {30'd0, o_dbg_state}, 32'd1);
        step(10);
        check("s2_state_rep", {30'd0, o_dbg_state}, 32'd2);
        step(20);
        i_btn[1] = 1'b0;            // release sampled from edge c+41
        step(5);
        check("s2_level_held", {29'd0, o_btn_level}, 32'h2);
        step(1);
        check("s2_level_drop", {29'd0, o_btn_level}, 32'h0);
        step(12);
        check("s2_state_idle", {30'd0, o_dbg_state}, 32'd0);
        score("s2");

        // 3: OK held 60 cycles gives one pulse and no repeat.
        c = cyc;
        i_btn[2] = 1'b1;
        expect_pulse(c + 7, 4'b0100);
        step(30);
        check("s3_level", {29'd0, o_btn_level}, 32'h4);
        check("s3_state", {30'd0, o_dbg_state}, 32'd0);
        step(30);
        i_btn[2] = 1'b0;
        step(12);
        score("s3");

        // 4: INC and OK rise together: OK wins, INC discarded for good.
        c = cyc;
        i_btn = 3'b101;
        expect_pulse(c + 7, 4'b0100);
        step(30);
        check("s4_level", {29'd0, o_btn_level}, 32'h5);
        i_btn = 3'b000;
        step(12);
        score("s4");

        // 5: INC into repeat, then DEC preempts and takes over repeating.
        c = cyc;
        i_btn = 3'b001;
        expect_pulse(c + 7,  4'b0001);
        expect_pulse(c + 17, 4'b0001);
        expect_pulse(c + 22, 4'b0001);
        expect_pulse(c + 27, 4'b0001);
        step(24);
        i_btn = 3'b011;
        expect_pulse(c + 31, 4'b0010);
        expect_pulse(c + 41, 4'b0010);
        expect_pulse(c + 46, 4'b0010);
        expect_pulse(c + 51, 4'b0010);
        step(24);
        i_btn = 3'b000;             // DEC level falls at c+54, blocking c+56
        step(14);
        score("s5");

        // 6: one-cycle reset mid-repeat with INC held, then a fresh press.
        c = cyc;
        i_btn = 3'b001;
        expect_pulse(c + 7,  4'b0001);
        expect_pulse(c + 17, 4'b0001);
        expect_pulse(c + 27, 4'b0001);
        step(19);
        w_rst = 1'b1;
        step(1);
        check("s6_rst_out",   {28'd0, o_user_input}, 32'd0);
        check("s6_rst_level", {29'd0, o_btn_level},  32'd0);
        check("s6_rst_state", {30'd0, o_dbg_state},  32'd0);
        w_rst = 1'b0;
        step(10);
        i_btn = 3'b000;             // level falls at c+36, blocking the c+37 repeat
        step(14);
        score("s6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
